// File: rtl/video_pkg.sv
// Shared video types for the 320x240 pipeline: pixel formats, frame geometry
// and the sink FSM state encoding.
package video_pkg;

  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } sink_state_t;

  // Truncating repack: keep the top nibble of each channel.
  function automatic rgb12_t to_rgb444(rgb30_t p);
    rgb12_t q;
    q.r = p.r[9:6];
    q.g = p.g[9:6];
    q.b = p.b[9:6];
    return q;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that adds a small increment each cycle and sticks at
// all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  assign sum = {1'b0, count} + (W+1)'(inc);

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= sum[W] ? '1 : sum[W-1:0];
  end

endmodule

// File: rtl/avst_frame_sink.sv
// Avalon-ST video sink: frames 30-bit pixels by SOP/EOP, repacks to RGB444 and
// writes them into the frame buffer, flagging framing errors.
//
// state  | meaning
// IDLE   | ready, discarding beats until an SOP starts a frame
// ACTIVE | capturing a frame, counter holds the next write address
// HOLD   | single-shot capture done, backpressure until arm/continuous
module avst_frame_sink
  import video_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int HEIGHT = FRAME_H,
  parameter int AW     = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [29:0]   sink_data,
  input  logic          sink_valid,
  input  logic          sink_sop,
  input  logic          sink_eop,
  output logic          sink_ready,
  input  logic          continuous,
  input  logic          arm,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_data,
  output logic          wr_en,
  output logic          frame_done,
  output logic          err_sop,
  output logic          err_short,
  output logic          err_long,
  output logic [7:0]    err_count
);

  localparam int            PIXELS   = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST_PIX = AW'(PIXELS - 1);

  sink_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_d;
  logic          accept;
  logic          we_d, done_d, esop_d, eshort_d, elong_d;
  logic [1:0]    err_inc;

  assign accept = sink_valid & sink_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = cnt_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    esop_d   = 1'b0;
    eshort_d = 1'b0;
    elong_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && sink_sop) begin
          we_d   = 1'b1;
          addr_d = '0;
          if (sink_eop) begin
            eshort_d = 1'b1;
          end else begin
            state_d = ACTIVE;
            cnt_d   = AW'(1);
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          we_d = 1'b1;
          if (sink_sop) begin
            // Restart: this beat becomes pixel 0 of a fresh frame.
            esop_d = 1'b1;
            addr_d = '0;
            cnt_d  = AW'(1);
            if (sink_eop) begin
              eshort_d = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end
          end else if (cnt_q == LAST_PIX) begin
            done_d  = 1'b1;
            elong_d = ~sink_eop;
            cnt_d   = '0;
            state_d = continuous ? IDLE : HOLD;
          end else if (sink_eop) begin
            eshort_d = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      HOLD: begin
        if (arm || continuous) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= continuous ? IDLE : HOLD;
      sink_ready <= continuous;
      cnt_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_sop    <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sink_ready <= (state_d != HOLD);
      cnt_q      <= cnt_d;
      wr_en      <= we_d;
      wr_addr    <= addr_d;
      if (we_d) wr_data <= to_rgb444(rgb30_t'(sink_data));
      frame_done <= done_d;
      err_sop    <= esop_d;
      err_short  <= eshort_d;
      err_long   <= elong_d;
    end
  end

  assign err_inc = {1'b0, esop_d} + {1'b0, eshort_d} + {1'b0, elong_d};

  sat_counter #(.W(8)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_avst_frame_sink.sv
// Bench for avst_frame_sink on a reduced 16x4 frame: vector table for the
// single-cycle corners, hand sequences for whole-frame behaviour.
module tb_avst_frame_sink;
  import video_pkg::*;

  localparam int W = 16, H = 4, AW = 7, PIX = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic [29:0]   sink_data;
  logic          sink_valid, sink_sop, sink_eop, sink_ready;
  logic          continuous, arm;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          wr_en, frame_done, err_sop, err_short, err_long;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  avst_frame_sink #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .continuous(continuous), .arm(arm), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .frame_done(frame_done), .err_sop(err_sop),
    .err_short(err_short), .err_long(err_long), .err_count(err_count)
  );

  int checks = 0, errors = 0;
  int n_we = 0, n_done = 0;

  always @(negedge clk) begin
    if (wr_en) n_we++;
    if (frame_done) n_done++;
  end

  typedef struct {
    logic        valid, sop, eop;
    logic [29:0] data;
    logic        e_we;
    logic [6:0]  e_addr;
    logic [11:0] e_wd;
    logic        e_done, e_esop, e_esh, e_el, e_rdy;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp444(input logic [29:0] d);
    return {d[29:26], d[19:16], d[9:6]};
  endfunction

  function automatic logic [29:0] pix(input int i);
    logic [9:0] r, g, b;
    r = 10'(i * 37);
    g = 10'(i * 11 + 5);
    b = 10'(1023 - i);
    return {r, g, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat(input string tag, input logic v, input logic sop, input logic eop,
                         input logic [29:0] d, input logic e_we, input int e_addr,
                         input logic e_done, input logic e_es, input logic e_esh,
                         input logic e_el, input logic e_rdy);
    sink_valid = v;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_data  = d;
    tick();
    chk({tag, ".wr_en"}, wr_en, e_we);
    if (e_we) begin
      chk({tag, ".wr_addr"}, wr_addr, e_addr);
      chk({tag, ".wr_data"}, wr_data, exp444(d));
    end
    chk({tag, ".frame_done"}, frame_done, e_done);
    chk({tag, ".err_sop"}, err_sop, e_es);
    chk({tag, ".err_short"}, err_short, e_esh);
    chk({tag, ".err_long"}, err_long, e_el);
    chk({tag, ".sink_ready"}, sink_ready, e_rdy);
  endtask

  task automatic do_reset(input logic cont);
    reset      = 1'b1;
    continuous = cont;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    arm        = 1'b0;
    tick();
    tick();
    chk("rst.wr_en", wr_en, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.errs", {err_sop, err_short, err_long}, 0);
    chk("rst.err_count", err_count, 0);
    chk("rst.sink_ready", sink_ready, cont);
    reset = 1'b0;
  endtask

  task automatic send_frame(input string tag, input int first, input logic with_eop,
                            input logic rdy_after);
    for (int i = first; i < PIX; i++) begin
      logic last;
      last = (i == PIX - 1);
      do_beat(tag, 1'b1, i == 0, last && with_eop, pix(i), 1'b1, i,
              last, 1'b0, 1'b0, last && !with_eop, last ? rdy_after : 1'b1);
    end
  endtask

  initial begin
    int k, we0, done0;
    sink_data = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 30'h3FF00000, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 30'h3FF00000, 1'b1, 7'd0, 12'hF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 30'h00000000, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 30'h3FF00000, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 30'h000FFC00, 1'b1, 7'd0, 12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 30'h000003FF, 1'b1, 7'd1, 12'h00F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 30'h3FFFFFFF, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, {10'h155, 10'h2AA, 10'h0F0}, 1'b1, 7'd2, 12'h5A3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 30'h3FFFFFFF, 1'b1, 7'd0, 12'hFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 30'h00000000, 1'b1, 7'd1, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 30'h3FF00000, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};

    do_reset(1'b1);
    for (int n = 0; n < 11; n++) begin
      sink_valid = vecs[n].valid;
      sink_sop   = vecs[n].sop;
      sink_eop   = vecs[n].eop;
      sink_data  = vecs[n].data;
      tick();
      chk($sformatf("vec%0d.wr_en", n), wr_en, vecs[n].e_we);
      if (vecs[n].e_we) begin
        chk($sformatf("vec%0d.wr_addr", n), wr_addr, vecs[n].e_addr);
        chk($sformatf("vec%0d.wr_data", n), wr_data, vecs[n].e_wd);
      end
      chk($sformatf("vec%0d.frame_done", n), frame_done, vecs[n].e_done);
      chk($sformatf("vec%0d.err_sop", n), err_sop, vecs[n].e_esop);
      chk($sformatf("vec%0d.err_short", n), err_short, vecs[n].e_esh);
      chk($sformatf("vec%0d.err_long", n), err_long, vecs[n].e_el);
      chk($sformatf("vec%0d.sink_ready", n), sink_ready, vecs[n].e_rdy);
      chk($sformatf("vec%0d.err_count", n), err_count, vecs[n].e_cnt);
    end

    // Clean frame, first pixel pure red.
    do_reset(1'b1);
    we0 = n_we; done0 = n_done;
    do_beat("clean0", 1'b1, 1'b1, 1'b0, 30'h3FF00000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clean0.red", wr_data, 12'hF00);
    send_frame("clean", 1, 1'b1, 1'b1);
    #6;
    chk("clean.n_writes", n_we - we0, PIX);
    chk("clean.n_done", n_done - done0, 1);
    chk("clean.err_count", err_count, 0);

    // Early EOP at beat 10, then a stray beat, then a full frame.
    for (int i = 0; i <= 10; i++)
      do_beat("early", 1'b1, i == 0, i == 10, pix(i), 1'b1, i, 1'b0, 1'b0, i == 10, 1'b0, 1'b1);
    do_beat("early.discard", 1'b1, 1'b0, 1'b0, pix(3), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("early.next", 0, 1'b1, 1'b1);
    chk("early.err_count", err_count, 1);

    // SOP arriving at beat 20 restarts the frame.
    do_reset(1'b1);
    for (int i = 0; i < 20; i++)
      do_beat("midsop.pre", 1'b1, i == 0, 1'b0, pix(i + 5), 1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_beat("midsop.sop", 1'b1, 1'b1, 1'b0, pix(0), 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame("midsop", 1, 1'b1, 1'b1);
    chk("midsop.err_count", err_count, 1);

    // Missing EOP, then 10 trailing non-SOP beats.
    do_reset(1'b1);
    send_frame("noeop", 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      do_beat("noeop.extra", 1'b1, 1'b0, 1'b0, pix(i), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("noeop.err_count", err_count, 1);

    // Single-shot: held off until armed, one frame per arm.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++)
      do_beat("ss.hold0", 1'b1, 1'b1, 1'b0, pix(0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    arm = 1'b1;
    do_beat("ss.arm1", 1'b1, 1'b1, 1'b0, pix(0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    arm = 1'b0;
    send_frame("ss.f1", 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      do_beat("ss.hold1", 1'b1, 1'b1, 1'b0, pix(0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    arm = 1'b1;
    do_beat("ss.arm2", 1'b1, 1'b1, 1'b0, pix(0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    arm = 1'b0;
    send_frame("ss.f2", 0, 1'b1, 1'b0);
    do_beat("ss.hold2", 1'b1, 1'b1, 1'b0, pix(0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ss.err_count", err_count, 0);

    // Throttled valid, reset mid-frame at beat 33.
    do_reset(1'b1);
    done0 = n_done;
    k = 0;
    while (k < 33) begin
      do_beat("thr", 1'b1, k == 0, 1'b0, pix(k), 1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      do_beat("thr.gap", 1'b0, 1'b0, 1'b0, pix(k + 1), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    reset = 1'b1;
    do_beat("thr.rst", 1'b1, 1'b0, 1'b0, pix(k), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      do_beat("thr.discard", 1'b1, 1'b0, 1'b0, pix(i + 40), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_beat("thr.sop", 1'b1, 1'b1, 1'b0, pix(7), 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sink_valid = 1'b0;
    #6;
    chk("thr.n_done", n_done - done0, 0);
    chk("thr.err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
